// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for the 16-bit accumulator ALU: issues an optional BR load,
// one operation pulse, waits for the result and hands ACC/high/flag back over valid/ready.
module alu_op_sequencer #(
  parameter int DATA_W      = 16,
  parameter int CSW         = 32,
  parameter int MULDIV_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic              op_load_br,
  input  logic [DATA_W-1:0] op_operand,
  output logic [CSW-1:0]    control_signal,
  output logic [DATA_W-1:0] br_out,
  input  logic [DATA_W-1:0] alu_low,
  input  logic [DATA_W-1:0] alu_high,
  input  logic              alu_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_low,
  output logic [DATA_W-1:0] res_high,
  output logic              res_flag,
  output logic              res_err,
  output logic              busy
);

  localparam int BIT_LOAD = 28;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CSW-1:0]      ctrl_q, ctrl_d;
  logic [DATA_W-1:0]   br_shadow_q, br_shadow_d;
  logic [3:0]          code_q, code_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_low_q, res_low_d;
  logic [DATA_W-1:0]   res_high_q, res_high_d;
  logic                res_flag_q, res_flag_d;
  logic                res_err_q, res_err_d;

  // One-hot ALU control bit for a legal opcode; illegal codes map to an all-zero word.
  function automatic logic [CSW-1:0] op_bit(input logic [3:0] code);
    logic [CSW-1:0] w;
    w = '0;
    case (code)
      4'd0:    w[8]  = 1'b1;
      4'd1:    w[9]  = 1'b1;
      4'd2:    w[15] = 1'b1;
      4'd3:    w[16] = 1'b1;
      4'd4:    w[17] = 1'b1;
      4'd5:    w[18] = 1'b1;
      4'd6:    w[19] = 1'b1;
      4'd7:    w[20] = 1'b1;
      4'd8:    w[21] = 1'b1;
      4'd9:    w[22] = 1'b1;
      4'd10:   w[23] = 1'b1;
      4'd11:   w[24] = 1'b1;
      4'd12:   w[25] = 1'b1;
      4'd13:   w[26] = 1'b1;
      default: w     = '0;
    endcase
    return w;
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return code > 4'd13;
  endfunction

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_DIV);
  endfunction

  always_comb begin
    state_d     = state_q;
    ctrl_d      = '0;
    br_shadow_d = br_shadow_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_low_d   = res_low_q;
    res_high_d  = res_high_q;
    res_flag_d  = res_flag_q;
    res_err_d   = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          code_d = op_code;
          if (is_illegal(op_code)) begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end else if (op_load_br) begin
            state_d          = S_LOAD;
            br_shadow_d      = op_operand;
            ctrl_d[BIT_LOAD] = 1'b1;
          end else if ((op_code == OP_DIV) && (br_shadow_q == '0)) begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end else begin
            state_d = S_EXEC;
            ctrl_d  = op_bit(op_code);
          end
        end
      end

      // The divisor check happens here so it sees the operand just loaded.
      S_LOAD: begin
        if ((code_q == OP_DIV) && (br_shadow_q == '0)) begin
          state_d     = S_RESP;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
          ctrl_d  = op_bit(code_q);
        end
      end

      S_EXEC: begin
        if (is_muldiv(code_q) && (MULDIV_WAIT > 0)) begin
          state_d = S_WAIT;
          cnt_d   = 4'(MULDIV_WAIT - 1);
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_CAPTURE: begin
        state_d     = S_RESP;
        res_valid_d = 1'b1;
        res_low_d   = alu_low;
        res_high_d  = alu_high;
        res_flag_d  = alu_flag;
        res_err_d   = 1'b0;
      end

      S_RESP: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      br_shadow_q <= '0;
      code_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_low_q   <= '0;
      res_high_q  <= '0;
      res_flag_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      br_shadow_q <= br_shadow_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_low_q   <= res_low_d;
      res_high_q  <= res_high_d;
      res_flag_q  <= res_flag_d;
      res_err_q   <= res_err_d;
    end
  end

  assign op_ready       = (state_q == S_IDLE) && !rst;
  assign busy           = (state_q != S_IDLE);
  assign control_signal = ctrl_q;
  assign br_out         = br_shadow_q;
  assign res_valid      = res_valid_q;
  assign res_low        = res_low_q;
  assign res_high       = res_high_q;
  assign res_flag       = res_flag_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU reacts to control_signal, while a separate
// reference model predicts every response from the request stream alone.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic        op_load_br;
  logic [15:0] op_operand;
  logic [31:0] control_signal;
  logic [15:0] br_out;
  logic [15:0] alu_low;
  logic [15:0] alu_high;
  logic        alu_flag;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_low;
  logic [15:0] res_high;
  logic        res_flag;
  logic        res_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.DATA_W(16), .CSW(32), .MULDIV_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_load_br(op_load_br), .op_operand(op_operand),
    .control_signal(control_signal), .br_out(br_out),
    .alu_low(alu_low), .alu_high(alu_high), .alu_flag(alu_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_low(res_low), .res_high(res_high), .res_flag(res_flag),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU arithmetic: returns {high, acc} after applying operation op.
  function automatic logic [31:0] alu_fn(input int op, input logic [15:0] acc, hi, br);
    logic [15:0] r;
    logic [31:0] p;
    r = acc;
    case (op)
      0:  r = 16'h0;
      1:  r = acc + br;
      2:  r = acc - br;
      3:  begin p = {16'h0, acc} * {16'h0, br}; return p; end
      4:  begin
            if (br == 16'h0) return {hi, acc};
            return {acc % br, acc / br};
          end
      5:  r = acc << 1;
      6:  r = acc >> 1;
      7:  r = acc <<< 1;
      8:  r = $signed(acc) >>> 1;
      9:  r = acc & br;
      10: r = acc | br;
      11: r = ~acc;
      12: r = acc ^ br;
      13: r = ~(acc ^ br);
      default: r = acc;
    endcase
    return {hi, r};
  endfunction

  function automatic int bitOf(input int k);
    if (k == 0) return 8;
    if (k == 1) return 9;
    return k + 13;
  endfunction

  // Behavioural ALU: never reset by the sequencer, it only reacts to control bits.
  logic [15:0] alu_acc = 16'h0;
  logic [15:0] alu_hi  = 16'h0;
  logic [15:0] alu_br  = 16'h0;
  assign alu_low  = alu_acc;
  assign alu_high = alu_hi;
  assign alu_flag = alu_acc[15];

  always @(posedge clk) begin : alu_model
    int op;
    op = -1;
    for (int k = 0; k < 14; k++)
      if (control_signal[bitOf(k)]) op = k;
    if (control_signal[28]) alu_br <= br_out;
    else if (op >= 0) {alu_hi, alu_acc} <= alu_fn(op, alu_acc, alu_hi, alu_br);
  end

  // Reference model state.
  logic [15:0] ref_acc = 16'h0, ref_hi = 16'h0, ref_br = 16'h0, ref_shadow = 16'h0;
  logic [15:0] exp_low = 16'h0, exp_high = 16'h0;
  logic        exp_flag = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    for (int i = 0; i < 20 && op_ready !== 1'b1; i++) @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(op_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic load, input logic [15:0] operand,
                               input int hold, input string tag);
    logic        illegal, err, got;
    logic [15:0] divisor, br_at_load;
    logic [31:0] seen[$];
    logic [31:0] want[$];
    int          lat, exp_lat, bad_onehot, bad_hold;

    illegal = (code >= 4'd14);
    divisor = (load && !illegal) ? operand : ref_shadow;
    err     = illegal || (code == 4'd4 && divisor == 16'h0);
    if (load && !illegal) begin
      ref_br     = operand;
      ref_shadow = operand;
      want.push_back(32'h1 << 28);
    end
    if (!err) begin
      want.push_back(32'h1 << bitOf(int'(code)));
      {ref_hi, ref_acc} = alu_fn(int'(code), ref_acc, ref_hi, ref_br);
      exp_low  = ref_acc;
      exp_high = ref_hi;
      exp_flag = ref_acc[15];
    end
    exp_lat = (load ? 4 : 3) + ((code == 4'd3 || code == 4'd4) ? 2 : 0);

    waitReady(tag);
    op_valid   = 1'b1;
    op_code    = code;
    op_load_br = load;
    op_operand = operand;
    @(posedge clk);
    #1;
    op_valid = 1'b0;

    got = 1'b0; lat = 0; bad_onehot = 0; br_at_load = 16'h0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (control_signal != 32'h0) begin
        seen.push_back(control_signal);
        if (control_signal[28]) br_at_load = br_out;
      end
      if ($countones(control_signal) > 1) bad_onehot++;
      if (res_valid) begin got = 1'b1; lat = c; end
    end
    checkOutput({tag, "_resp_seen"}, 32'(got), 32'd1);
    if (!err) checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_ctrl_count"}, 32'(seen.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < seen.size(); i++)
      checkOutput({tag, "_ctrl_word"}, seen[i], want[i]);
    checkOutput({tag, "_onehot"}, 32'(bad_onehot), 32'd0);
    if (load && !illegal) checkOutput({tag, "_br_out"}, 32'(br_at_load), 32'(operand));
    checkOutput({tag, "_res_low"}, 32'(res_low), 32'(exp_low));
    checkOutput({tag, "_res_high"}, 32'(res_high), 32'(exp_high));
    checkOutput({tag, "_res_flag"}, 32'(res_flag), 32'(exp_flag));
    checkOutput({tag, "_res_err"}, 32'(res_err), 32'(err));

    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      op_valid   = 1'b1;
      op_code    = 4'($urandom);
      op_load_br = 1'($urandom);
      op_operand = 16'($urandom);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_low !== exp_low || res_high !== exp_high ||
          res_flag !== exp_flag || res_err !== err || op_ready !== 1'b0) bad_hold++;
    end
    if (hold > 0) checkOutput({tag, "_hold_stable"}, 32'(bad_hold), 32'd0);

    res_ready = 1'b1;
    op_valid  = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_after_hs_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_after_hs_ready"}, 32'(op_ready), 32'd1);
  endtask

  // Starts a MUL with load and resets the sequencer cyc cycles after acceptance.
  task automatic resetDuring(input int cyc, input string tag);
    waitReady(tag);
    op_valid   = 1'b1;
    op_code    = 4'd3;
    op_load_br = 1'b1;
    op_operand = 16'd4;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_ctrl"}, control_signal, 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_res_low"}, 32'(res_low), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    // The MUL pulse was already on the bus before the abort, so the ALU did execute it.
    ref_br = 16'd4;
    {ref_hi, ref_acc} = alu_fn(3, ref_acc, ref_hi, ref_br);
    ref_shadow = 16'h0;
    exp_low = 16'h0; exp_high = 16'h0; exp_flag = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_load_br = 1'b0;
    op_operand = 16'h0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", control_signal, 32'h0);
    checkOutput("rst_br_out", 32'(br_out), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_op_ready_in_rst", 32'(op_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_op_ready", 32'(op_ready), 32'd1);

    applyStimulus(4'd0, 1'b0, 16'h0, 0, "clr");
    applyStimulus(4'd1, 1'b1, 16'd5, 0, "add5");
    applyStimulus(4'd2, 1'b1, 16'd7, 0, "sub7");
    applyStimulus(4'd4, 1'b1, 16'd0, 0, "div0_load");
    applyStimulus(4'd0, 1'b1, 16'd0, 0, "clr_br0");
    applyStimulus(4'd4, 1'b0, 16'd9, 0, "div0_shadow");
    applyStimulus(4'd1, 1'b1, 16'd3, 0, "add3");
    applyStimulus(4'd3, 1'b1, 16'd4, 0, "mul4");
    applyStimulus(4'd14, 1'b1, 16'h1234, 0, "illegal14");
    applyStimulus(4'd15, 1'b0, 16'h0, 0, "illegal15");
    applyStimulus(4'd4, 1'b1, 16'd5, 0, "div5");
    applyStimulus(4'd1, 1'b1, 16'd1, 10, "hold10");
    resetDuring(2, "rst_exec");
    resetDuring(3, "rst_wait");
    applyStimulus(4'd4, 1'b0, 16'h0, 0, "div_after_rst");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] opnd;
      opnd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), opnd,
                    $urandom_range(0, 3), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
